// File: rtl/sdram_traffic_checker.sv
// SDRAM traffic checker: writes a pattern block over Avalon-MM, then reads
// it back with bounded outstanding reads and counts data mismatches.
module sdram_traffic_checker #(
   parameter int ADDR_W  = 25,
   parameter int DATA_W  = 16,
   parameter int MAX_OUT = 4,
   parameter int CNT_W   = 16
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [CNT_W-1:0]    num_words,
   input  logic [1:0]          mode,
   output logic [ADDR_W-1:0]   avm_address,
   output logic [DATA_W/8-1:0] avm_byteenable_n,
   output logic                avm_chipselect,
   output logic                avm_read_n,
   output logic                avm_write_n,
   output logic [DATA_W-1:0]   avm_writedata,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_readdatavalid,
   input  logic                avm_waitrequest,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [CNT_W-1:0]    err_count,
   output logic [ADDR_W-1:0]   first_err_addr
);

   localparam logic [15:0] SEED = 16'hACE1;

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  num_q, num_d;
   logic [1:0]        mode_q, mode_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [15:0]       wlfsr_q, wlfsr_d;
   logic [CNT_W-1:0]  cidx_q, cidx_d;
   logic [15:0]       clfsr_q, clfsr_d;
   logic [3:0]        out_q, out_d;
   logic [CNT_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] ferr_q, ferr_d;
   logic              fset_q, fset_d;
   logic              pass_q, pass_d;

   logic [ADDR_W-1:0] cmd_addr, cmp_addr;
   logic [DATA_W-1:0] exp_data;
   logic can_rd, wr_acc, rd_acc, last, active, bump;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   function automatic logic [DATA_W-1:0] pattern(
      input logic [1:0]        m,
      input logic [ADDR_W-1:0] a,
      input logic              odd,
      input logic [15:0]       l
   );
      logic [DATA_W-1:0] r;
      for (int b = 0; b < DATA_W; b++) r[b] = l[b % 16];
      case (m)
         2'd0:    pattern = DATA_W'(a);
         2'd1:    pattern = ~DATA_W'(a);
         2'd2:    pattern = r;
         default: pattern = odd ? {(DATA_W/2){2'b10}}
                                 : {(DATA_W/2){2'b01}};
      endcase
   endfunction

   assign active   = (state_q == S_WRITE) || (state_q == S_READ) ||
                     (state_q == S_DRAIN);
   assign cmd_addr = base_q + ADDR_W'(idx_q);
   assign cmp_addr = base_q + ADDR_W'(cidx_q);
   assign exp_data = pattern(mode_q, cmp_addr, cidx_q[0], clfsr_q);
   assign can_rd   = out_q < 4'(MAX_OUT);
   assign wr_acc   = (state_q == S_WRITE) && !avm_waitrequest;
   assign rd_acc   = (state_q == S_READ) && can_rd && !avm_waitrequest;
   assign last     = idx_q == num_q - CNT_W'(1);

   assign busy           = active;
   assign done           = state_q == S_DONE;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      num_d   = num_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      wlfsr_d = wlfsr_q;
      cidx_d  = cidx_q;
      clfsr_d = clfsr_q;
      out_d   = out_q;
      err_d   = err_q;
      ferr_d  = ferr_q;
      fset_d  = fset_q;
      pass_d  = pass_q;
      bump    = 1'b0;

      avm_chipselect   = 1'b0;
      avm_read_n       = 1'b1;
      avm_write_n      = 1'b1;
      avm_byteenable_n = '1;
      avm_address      = '0;
      avm_writedata    = '0;

      case (state_q)
         S_WRITE: begin
            avm_chipselect   = 1'b1;
            avm_write_n      = 1'b0;
            avm_byteenable_n = '0;
            avm_address      = cmd_addr;
            avm_writedata    = pattern(mode_q, cmd_addr, idx_q[0], wlfsr_q);
         end
         S_READ: begin
            if (can_rd) begin
               avm_chipselect   = 1'b1;
               avm_read_n       = 1'b0;
               avm_byteenable_n = '0;
               avm_address      = cmd_addr;
            end
         end
         default: ;
      endcase

      // data with nothing outstanding is a protocol error, not a compare
      if (active && avm_readdatavalid) begin
         bump = (out_q == '0) || (avm_readdata != exp_data);
         if (out_q != '0) begin
            out_d   = out_q - 4'd1;
            cidx_d  = cidx_q + CNT_W'(1);
            clfsr_d = lfsr_step(clfsr_q);
         end
      end
      if (rd_acc) out_d = out_d + 4'd1;
      if (bump) begin
         if (err_q != '1) err_d = err_q + CNT_W'(1);
         if (!fset_q) begin
            ferr_d = cmp_addr;
            fset_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               base_d  = base_addr;
               num_d   = num_words;
               mode_d  = mode;
               idx_d   = '0;
               cidx_d  = '0;
               wlfsr_d = SEED;
               clfsr_d = SEED;
               out_d   = '0;
               err_d   = '0;
               ferr_d  = '0;
               fset_d  = 1'b0;
               pass_d  = (num_words == '0);
               state_d = (num_words == '0) ? S_DONE : S_WRITE;
            end
         end
         S_WRITE: begin
            if (wr_acc) begin
               if (last) begin
                  idx_d   = '0;
                  wlfsr_d = SEED;
                  state_d = S_READ;
               end else begin
                  idx_d   = idx_q + CNT_W'(1);
                  wlfsr_d = lfsr_step(wlfsr_q);
               end
            end
         end
         S_READ: begin
            if (rd_acc) begin
               if (last) state_d = S_DRAIN;
               else idx_d = idx_q + CNT_W'(1);
            end
         end
         S_DRAIN: begin
            if (out_d == '0) begin
               state_d = S_DONE;
               pass_d  = (err_d == '0);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         num_q   <= '0;
         mode_q  <= '0;
         idx_q   <= '0;
         wlfsr_q <= SEED;
         cidx_q  <= '0;
         clfsr_q <= SEED;
         out_q   <= '0;
         err_q   <= '0;
         ferr_q  <= '0;
         fset_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         num_q   <= num_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         wlfsr_q <= wlfsr_d;
         cidx_q  <= cidx_d;
         clfsr_q <= clfsr_d;
         out_q   <= out_d;
         err_q   <= err_d;
         ferr_q  <= ferr_d;
         fset_q  <= fset_d;
         pass_q  <= pass_d;
      end
   end

endmodule

// File: tb/tb_sdram_traffic_checker.sv
// Bench for sdram_traffic_checker: Avalon memory model with latency and
// random stalls, checked against a word-list model of the test run.
module tb_sdram_traffic_checker;

   localparam int AW = 25;
   localparam int DW = 16;
   localparam int CW = 16;
   localparam int MO = 4;

   logic          clk = 1'b0;
   logic          reset_reset_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] num_words;
   logic [1:0]    mode;
   logic [AW-1:0] avm_address;
   logic [1:0]    avm_byteenable_n;
   logic          avm_chipselect, avm_read_n, avm_write_n;
   logic [DW-1:0] avm_writedata;
   logic [DW-1:0] avm_readdata = '0;
   logic          avm_readdatavalid = 1'b0;
   logic          avm_waitrequest = 1'b0;
   logic          busy, done, pass;
   logic [CW-1:0] err_count;
   logic [AW-1:0] first_err_addr;

   always #5 clk = ~clk;

   sdram_traffic_checker #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO), .CNT_W(CW)
   ) dut (
      .clk_clk(clk), .reset_reset_n(reset_reset_n), .start(start),
      .base_addr(base_addr), .num_words(num_words), .mode(mode),
      .avm_address(avm_address), .avm_byteenable_n(avm_byteenable_n),
      .avm_chipselect(avm_chipselect), .avm_read_n(avm_read_n),
      .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done),
      .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
   );

   typedef struct { int due; logic [DW-1:0] data; } rsp_t;

   int total = 0, passed = 0, cyc = 0;
   logic [DW-1:0] mem [logic [AW-1:0]];
   rsp_t rq[$];
   bit   track = 0, stall_en = 0, prev_stall = 0;
   int   lat = 3;
   logic [AW-1:0] base_m = '0;
   int   n_m = 0, mode_m = 0, cor_m = -1;
   int   wr_n = 0, rd_n = 0, rdv_n = 0, out_m = 0, max_m = 0;
   logic [AW-1:0] alog[$];
   logic [DW-1:0] dlog[$];
   logic [45:0] prev_cmd = '0, cur_cmd;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         passed++;
   endtask

   function automatic logic [15:0] lfsr_at(input int k);
      int v = 'hACE1;
      int b;
      for (int j = 0; j < k; j++) begin
         b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
         v = (v >> 1) | (b << 15);
      end
      return 16'(v);
   endfunction

   function automatic logic [15:0] exp_word(input int m,
                                            input logic [AW-1:0] a,
                                            input int i);
      case (m)
         0:       return a[15:0];
         1:       return ~a[15:0];
         2:       return lfsr_at(i);
         default: return (i % 2 == 1) ? 16'hAAAA : 16'h5555;
      endcase
   endfunction

   // memory model plus per-cycle bus checks
   always @(negedge clk) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] rd;
      cyc++;
      cur_cmd = {avm_chipselect, avm_read_n, avm_write_n, avm_byteenable_n,
                 avm_address, avm_writedata};
      if (busy === 1'b0)
         chk("idle_bus", cur_cmd, {3'b011, 2'b11, 25'd0, 16'd0});
      if (prev_stall && reset_reset_n)
         chk("stall_hold", cur_cmd, prev_cmd);
      avm_waitrequest = stall_en && ($urandom_range(0, 2) == 0);
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         avm_readdatavalid = 1'b1;
         avm_readdata = rq[0].data;
         void'(rq.pop_front());
         if (track) begin
            out_m--;
            rdv_n++;
         end
      end else begin
         avm_readdatavalid = 1'b0;
         avm_readdata = 16'($urandom);
      end
      if (avm_chipselect === 1'b1 && !avm_waitrequest) begin
         if (!avm_write_n) begin
            ea = base_m + AW'(wr_n);
            if (track)
               chk("write_cmd", {avm_address, avm_writedata, avm_byteenable_n},
                   {ea, exp_word(mode_m, ea, wr_n), 2'b00});
            mem[avm_address] = avm_writedata;
            alog.push_back(avm_address);
            dlog.push_back(avm_writedata);
            wr_n++;
         end else if (!avm_read_n) begin
            ea = base_m + AW'(rd_n);
            if (track) chk("read_addr", avm_address, ea);
            rd = mem.exists(avm_address) ? mem[avm_address] : '0;
            if (track && rd_n == cor_m) rd = rd ^ 16'h0001;
            rq.push_back('{cyc + lat, rd});
            rd_n++;
            if (track) begin
               out_m++;
               if (out_m > max_m) max_m = out_m;
               chk("outstanding_bound", 64'(out_m <= MO), 1);
            end
         end
      end
      prev_stall = avm_chipselect && avm_waitrequest && reset_reset_n;
      prev_cmd = cur_cmd;
   end

   task automatic drain_q();
      int k = 0;
      while (rq.size() > 0 && k < 200) begin
         @(negedge clk); #1;
         k++;
      end
      chk("resp_drain", 64'(rq.size()), 0);
   endtask

   task automatic setup(input logic [AW-1:0] b, input int n, input int m,
                        input int l, input bit st, input int cor);
      drain_q();
      base_m = b; n_m = n; mode_m = m; lat = l; stall_en = st; cor_m = cor;
      wr_n = 0; rd_n = 0; rdv_n = 0; out_m = 0; max_m = 0;
      alog.delete(); dlog.delete();
      track = 1;
      @(negedge clk); #1;
      base_addr = b; num_words = CW'(n); mode = 2'(m); start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run(input logic [AW-1:0] b, input int n, input int m,
                      input int l, input bit st, input int cor,
                      input bit restart);
      int k = 0;
      int ne;
      setup(b, n, m, l, st, cor);
      chk("start_busy", busy, n > 0);
      chk("start_done", done, n == 0);
      chk("start_err_clr", err_count, 0);
      if (restart) begin
         base_addr = '0; num_words = '0; mode = 2'd1; start = 1'b1;
         @(negedge clk); #1;
         start = 1'b0;
      end
      while (done !== 1'b1 && k < 3000) begin
         @(negedge clk); #1;
         k++;
      end
      chk("done_seen", done, 1);
      ne = (cor >= 0 && cor < n) ? 1 : 0;
      chk("rdv_at_done", rdv_n, n);
      chk("writes", wr_n, n);
      chk("reads", rd_n, n);
      chk("busy_end", busy, 0);
      chk("err_count", err_count, ne);
      chk("pass", pass, ne == 0);
      chk("first_err_addr", first_err_addr, ne ? b + AW'(cor) : '0);
   endtask

   initial begin
      int k;
      reset_reset_n = 1'b0;
      start = 1'b0;
      base_addr = '0;
      num_words = '0;
      mode = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_count, 0);
      chk("rst_ferr", first_err_addr, 0);
      reset_reset_n = 1'b1;

      chk("model_lfsr0", lfsr_at(0), 16'hACE1);
      chk("model_lfsr1", lfsr_at(1), 16'h5670);
      chk("model_lfsr2", lfsr_at(2), 16'hAB38);
      chk("model_mode1", exp_word(1, 25'h100, 0), 16'hFEFF);
      chk("model_mode3", exp_word(3, 25'h0, 1), 16'hAAAA);

      run(25'h000100, 8, 0, 3, 0, -1, 1);
      chk("t1_w0", {alog[0], dlog[0]}, {25'h100, 16'h0100});
      chk("t1_w7", {alog[7], dlog[7]}, {25'h107, 16'h0107});

      run(25'h002000, 4, 3, 3, 1, -1, 0);
      chk("t2_data", {dlog[0], dlog[1], dlog[2], dlog[3]},
          64'h5555AAAA5555AAAA);

      run(25'h000040, 16, 2, 3, 1, 5, 0);
      chk("t3_w1", dlog[1], 16'h5670);
      chk("t3_ferr", first_err_addr, 25'h45);

      run(25'h000010, 0, 2, 3, 0, -1, 0);

      run(25'h000300, 16, 1, 10, 0, -1, 0);
      chk("t4_max_out", max_m, MO);

      run(25'h1FFFFFE, 4, 0, 3, 1, -1, 0);
      chk("t5_addrs", {alog[0], alog[1], alog[2], alog[3]},
          {25'h1FFFFFE, 25'h1FFFFFF, 25'h0, 25'h1});

      // reset with two reads in flight
      setup(25'h000700, 12, 0, 10, 0, -1);
      k = 0;
      while (rd_n < 2 && k < 500) begin
         @(negedge clk); #1;
         k++;
      end
      chk("t7_reads_in_flight", 64'(rd_n >= 2), 1);
      @(posedge clk); #1;
      reset_reset_n = 1'b0;
      track = 0;
      @(posedge clk); #1;
      chk("t7_rst_bus", {avm_chipselect, avm_read_n, avm_write_n,
                         avm_byteenable_n, avm_address}, {3'b011, 2'b11, 25'd0});
      chk("t7_rst_status", {busy, done, pass, err_count, first_err_addr},
          '0);
      @(negedge clk); #1;
      reset_reset_n = 1'b1;
      drain_q();
      @(negedge clk); #1;
      chk("t7_late_ignored", {busy, done, err_count}, '0);
      run(25'h000500, 8, 2, 3, 1, -1, 0);

      for (int r = 0; r < 6; r++) begin
         int n = $urandom_range(1, 20);
         int cor = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
         run(AW'($urandom), n, $urandom_range(0, 3), $urandom_range(1, 8),
             1'($urandom_range(0, 1)), cor, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
